instruction_fetch_unit: RTL and testbench

Initiator side of the instruction-memory read interface. Owns the program counter and drives the word-aligned byte address into the instruction memory. Captures the returned instruction into the IF/ID pipeline register. Handles stall, branch redirect/flush and halt detection, and sits between the PC-update logic in ID and the decode stage.

---
 rtl/instruction_fetch_unit_if.sv | 40 ++++
 rtl/instruction_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: hazard/redirect controls in, instruction memory port and IF/ID register out.
// FETCH_ALIGN_CHECK_EN adds the Misaligned status output.
interface instruction_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            Stall;
    logic            BranchTaken;
    logic [XLEN-1:0] BranchTarget;
    logic [XLEN-1:0] IMemInstruction;
    logic [XLEN-1:0] IMemAddress;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] IF_ID_Instruction;
    logic [XLEN-1:0] IF_ID_PCPlus4;
    logic            IF_ID_Valid;
    logic [XLEN-1:0] FetchCount;
    logic            Halted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            Misaligned;
`endif

    // Fetch unit side: initiator toward instruction memory and decode
    modport master (
        input  Stall, BranchTaken, BranchTarget, IMemInstruction,
        output IMemAddress, PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
`ifdef FETCH_ALIGN_CHECK_EN
        output Misaligned,
`endif
        output FetchCount, Halted
    );

    // Environment side: hazard unit, ID redirect logic, memory, decode
    modport slave (
        output Stall, BranchTaken, BranchTarget, IMemInstruction,
        input  IMemAddress, PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid,
`ifdef FETCH_ALIGN_CHECK_EN
        input  Misaligned,
`endif
        input  FetchCount, Halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fills IF/ID, handles stall/redirect/halt.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise Misaligned.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
    input  logic                     Clk,
    input  logic                     Reset,
    instruction_fetch_unit_if.master bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] count_q, count_d;
    logic            halted_q, halted_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            misaligned_q, misaligned_d;
`endif

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] count_inc;
    logic            is_halt_word;

    assign pc_plus4     = pc_q + XLEN'(4);
    assign count_inc    = (count_q == {XLEN{1'b1}}) ? count_q : count_q + XLEN'(1);
    assign is_halt_word = (bus.IMemInstruction == HALT_WORD);

    // State and pipeline registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            count_q      <= '0;
            halted_q     <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            halted_q     <= halted_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    // Next-state and next-register values; redirect beats stall beats fetch
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        count_d      = count_q;
        halted_d     = halted_q;
`ifdef FETCH_ALIGN_CHECK_EN
        misaligned_d = misaligned_q;
`endif

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end

            RUN: begin
                if (bus.BranchTaken) begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (bus.BranchTarget[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                        halted_d     = 1'b1;
                        state_d      = HALTED;
                    end else begin
                        pc_d = bus.BranchTarget;
                    end
`else
                    pc_d = bus.BranchTarget & ~XLEN'(3);
`endif
                end else if (!bus.Stall) begin
                    instr_d = bus.IMemInstruction;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    count_d = count_inc;
                    if (is_halt_word) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end

            HALTED: begin
                instr_d = '0;
                pc4_d   = '0;
                valid_d = 1'b0;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.IMemAddress       = pc_q;
    assign bus.PC                = pc_q;
    assign bus.IF_ID_Instruction = instr_q;
    assign bus.IF_ID_PCPlus4     = pc4_q;
    assign bus.IF_ID_Valid       = valid_q;
    assign bus.FetchCount        = count_q;
    assign bus.Halted            = halted_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.Misaligned        = misaligned_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan sequence with literal
// expectations, then randomized stall/redirect/reset traffic against a behavioural model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] HALT = 32'h0000_000C;

    logic Clk;
    logic rst_n;
    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .HALT_WORD(HALT)
    ) dut (
        .Clk  (Clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem [1024];
    always_comb bus.IMemInstruction = mem[bus.IMemAddress[11:2]];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Behavioural model of what the fetch stage must show
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    bit          m_valid, m_halted, m_mis, m_boot;

    always @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
            m_valid = 0; m_halted = 0; m_mis = 0; m_boot = 1;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_halted) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
        end else if (bus.BranchTaken) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (bus.BranchTarget % 4 != 0) begin
                m_mis = 1; m_halted = 1;
            end else begin
                m_pc = bus.BranchTarget;
            end
`else
            m_pc = bus.BranchTarget - (bus.BranchTarget % 4);
`endif
        end else if (!bus.Stall) begin
            m_instr = mem[(m_pc / 4) % 1024];
            m_pc4   = m_pc + 4;
            m_valid = 1;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (m_instr == HALT) m_halted = 1;
            else m_pc = m_pc + 4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare of DUT against model
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("m_pc",     bus.PC,                m_pc);
            chk("m_addr",   bus.IMemAddress,       m_pc);
            chk("m_instr",  bus.IF_ID_Instruction, m_instr);
            chk("m_pc4",    bus.IF_ID_PCPlus4,     m_pc4);
            chk("m_valid",  32'(bus.IF_ID_Valid),  32'(m_valid));
            chk("m_count",  bus.FetchCount,        m_count);
            chk("m_halted", 32'(bus.Halted),       32'(m_halted));
`ifdef FETCH_ALIGN_CHECK_EN
            chk("m_mis",    32'(bus.Misaligned),   32'(m_mis));
`endif
        end
    end

    task automatic cyc(input bit st, input bit br, input logic [31:0] tgt);
        bus.Stall = st; bus.BranchTaken = br; bus.BranchTarget = tgt;
        @(negedge Clk);
    endtask

    task automatic ifid(input string name, input logic [31:0] i, input logic [31:0] p4,
                        input bit v, input logic [31:0] pc, input logic [31:0] cnt);
        chk({name, "_instr"}, bus.IF_ID_Instruction, i);
        chk({name, "_pc4"},   bus.IF_ID_PCPlus4,     p4);
        chk({name, "_valid"}, 32'(bus.IF_ID_Valid),  32'(v));
        chk({name, "_pc"},    bus.PC,                pc);
        chk({name, "_count"}, bus.FetchCount,        cnt);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge Clk);
        #2 rst_n = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 3);

        // Directed: reset values, boot bubble, sequential fetch
        repeat (2) @(negedge Clk);
        ifid("rst", 32'h0, 32'h0, 0, 32'h0, 32'h0);
        chk("rst_halted", 32'(bus.Halted), 32'h0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        cyc(0, 0, 0);
        ifid("boot", 32'h0, 32'h0, 0, 32'h0, 32'h0);
        cyc(0, 0, 0);
        ifid("f0", 32'd0, 32'd4, 1, 32'd4, 32'd1);
        cyc(0, 0, 0);
        ifid("f1", 32'd3, 32'd8, 1, 32'd8, 32'd2);
        // Stall at PC=8 for two edges
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        ifid("stall", 32'd3, 32'd8, 1, 32'd8, 32'd2);
        cyc(0, 0, 0);
        ifid("f2", 32'd6, 32'd12, 1, 32'd12, 32'd3);
        // Redirect overrides stall
        cyc(1, 1, 32'h40);
        ifid("br40", 32'h0, 32'h0, 0, 32'h40, 32'd3);
        cyc(0, 0, 0);
        ifid("f16", 32'd48, 32'h44, 1, 32'h44, 32'd4);
        // PC wrap at top of address space
        cyc(0, 1, 32'hFFFF_FFFC);
        chk("wrap_br_pc", bus.PC, 32'hFFFF_FFFC);
        cyc(0, 0, 0);
        ifid("wrap", 32'd3069, 32'h0, 1, 32'h0, 32'd5);
        // Misaligned redirect
        cyc(0, 1, 32'h42);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_pc", bus.PC, 32'h0);
        chk("mis_flag", 32'(bus.Misaligned), 32'h1);
        chk("mis_halted", 32'(bus.Halted), 32'h1);
`else
        chk("mis_pc", bus.PC, 32'h40);
        chk("mis_halted", 32'(bus.Halted), 32'h0);
`endif
        cyc(0, 0, 0);

        // Directed: halt word at word 5
        mem[4] = 32'd100;
        mem[5] = HALT;
        do_reset();
        for (int i = 0; i < 6; i++) cyc(0, 0, 0);
        ifid("halt", HALT, 32'h18, 1, 32'h14, 32'd6);
        chk("halt_flag", 32'(bus.Halted), 32'h1);
        cyc(0, 0, 0);
        ifid("halt_bub", 32'h0, 32'h0, 0, 32'h14, 32'd6);
        cyc(1, 1, 32'h0);
        ifid("halt_br", 32'h0, 32'h0, 0, 32'h14, 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pc", bus.PC, 32'h0);
        chk("midrst_halted", 32'(bus.Halted), 32'h0);
        chk("midrst_count", bus.FetchCount, 32'h0);
        @(negedge Clk);
        #2 rst_n = 1'b1;
        @(negedge Clk);

        // Randomized phase
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom % 20 == 0) ? HALT : $urandom;
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] tgt;
            case ($urandom % 4)
                0: tgt = {20'h0, 10'($urandom % 1024), 2'b00};
                1: tgt = $urandom;
                2: tgt = 32'hFFFF_FFFC;
                default: tgt = 32'($urandom % 4096);
            endcase
            if ($urandom % 64 == 0) do_reset();
            else cyc(($urandom % 4) == 0, ($urandom % 8) == 0, tgt);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
